// File: rtl/pc_fetch_pkg.sv
// Shared widths, reset defaults and state encodings for the fetch-PC generator.
package pc_fetch_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [HALF_W-1:0] half_t;

  localparam word_t RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam word_t IMEM_BYTES_DEFAULT = 32'h0000_4000;
  localparam word_t PC_INC             = 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

  // Unsigned window test done in 33 bits so base+size cannot wrap.
  function automatic logic in_window(input word_t pc, input word_t base, input word_t size);
    logic [WORD_W:0] lo;
    logic [WORD_W:0] hi;
    logic [WORD_W:0] pc_ext;
    lo     = {1'b0, base};
    hi     = {1'b0, base} + {1'b0, size};
    pc_ext = {1'b0, pc};
    return (pc_ext >= lo) && (pc_ext < hi);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-side bundle: hazard/imem controls and decode redirects in, fetch PC and status out.
interface pc_fetch_if;

  logic                  stall;
  logic                  imem_ready;
  logic                  pc_branch;
  pc_fetch_pkg::word_t   B_addr;
  logic                  J_en;
  pc_fetch_pkg::word_t   J_addr;
  logic                  JR_en;
  pc_fetch_pkg::word_t   JR_addr;
  pc_fetch_pkg::word_t   PC;
  pc_fetch_pkg::word_t   PC4;
  logic                  fetch_valid;
  logic                  redirect_pending;
  logic                  pc_misalign;
  logic                  pc_out_of_range;

  modport master (
    output stall, imem_ready, pc_branch, B_addr, J_en, J_addr, JR_en, JR_addr,
    input  PC, PC4, fetch_valid, redirect_pending, pc_misalign, pc_out_of_range
  );

  modport slave (
    input  stall, imem_ready, pc_branch, B_addr, J_en, J_addr, JR_en, JR_addr,
    output PC, PC4, fetch_valid, redirect_pending, pc_misalign, pc_out_of_range
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect slot: captures a redirect that arrives while fetch cannot advance.
module pc_redirect_buf
  import pc_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  redir,
  input  word_t redir_target,
  input  logic  advance,
  output logic  pending,
  output word_t pending_target
);

  pc_state_e state_reg, state_next;
  word_t     target_reg, target_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_RUN;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    case (state_reg)
      ST_RUN: begin
        if (!advance && redir) begin
          state_next  = ST_HOLD;
          target_next = redir_target;
        end
      end
      ST_HOLD: begin
        // A stalled decode re-presents its request, so the newest one wins.
        if (redir) target_next = redir_target;
        if (advance) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign pending        = (state_reg == ST_HOLD);
  assign pending_target = target_reg;

endmodule

// File: rtl/pc_fetch.sv
// Fetch PC register with delay-slot-style redirect (next step replaced, never flushed).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter word_t RESET_PC   = RESET_PC_DEFAULT,
  parameter word_t IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
  input logic      clk,
  input logic      reset,
  pc_fetch_if.slave bus
);

  logic  advance;
  logic  redir;
  logic  pending;
  logic  started_reg;
  word_t redir_target;
  word_t pending_target;
  word_t pc_reg, pc_next;

  assign advance = !bus.stall && bus.imem_ready;
  assign redir   = bus.JR_en | bus.J_en | bus.pc_branch;

  always_comb begin
    redir_target = bus.B_addr;
    if (bus.JR_en)     redir_target = bus.JR_addr;
    else if (bus.J_en) redir_target = bus.J_addr;
  end

  pc_redirect_buf u_redirect_buf (
    .clk            (clk),
    .reset          (reset),
    .redir          (redir),
    .redir_target   (redir_target),
    .advance        (advance),
    .pending        (pending),
    .pending_target (pending_target)
  );

  // A fresh request on the releasing cycle beats the buffered one.
  always_comb begin
    pc_next = pc_reg;
    if (advance) begin
      if (redir)        pc_next = redir_target;
      else if (pending) pc_next = pending_target;
      else              pc_next = pc_reg + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      started_reg <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      started_reg <= 1'b1;
    end
  end

  assign bus.PC               = pc_reg;
  assign bus.PC4              = pc_reg + PC_INC;
  assign bus.fetch_valid      = started_reg && bus.imem_ready;
  assign bus.redirect_pending = pending;
  assign bus.pc_misalign      = |pc_reg[1:0];
  assign bus.pc_out_of_range  = !in_window(pc_reg, RESET_PC, IMEM_BYTES);

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Next-PC and fetch-address generator at the front of the 5-stage MIPS pipeline.
- Consumes the redirect requests that the decode-stage branch unit produces: pc_branch/B_addr, the J-type target, and the JR register target.
- Holds the architectural fetch PC and honours the branch delay slot. A redirect that arrives while fetch cannot advance is buffered in a one-entry pending slot, so no redirect is lost across stalls or instruction-memory wait states.

Parameters:
RESET_PC, 32'h0000_3000, fetch address loaded on reset
IMEM_BYTES, 32'h0000_4000, size of instruction memory window starting at RESET_PC (range check)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit freezes IF/ID; PC must hold
imem_ready  input  1  instruction memory accepts current PC this cycle
pc_branch  input  1  conditional branch taken (decode stage)
B_addr  input  32  branch target
J_en  input  1  j/jal in decode
J_addr  input  32  jump target
JR_en  input  1  jr/jalr in decode
JR_addr  input  32  register target (forwarded rs)
PC  output  32  current fetch address
PC4  output  32  PC+4, to IF/ID
fetch_valid  output  1  PC presented to imem is a real fetch
redirect_pending  output  1  a buffered redirect awaits application
pc_misalign  output  1  PC[1:0] != 0 (AdEL, fetch side)
pc_out_of_range  output  1  PC outside [RESET_PC, RESET_PC+IMEM_BYTES)

Behaviour:
- Reset (async, any cycle, including mid-HOLD) sets:
  - PC=RESET_PC, state=RUN, pending_target=0.
  - fetch_valid=0 for the first cycle after reset deassert, then 1.
  - redirect_pending=0; both flags=0.
- advance = !stall && imem_ready.
- redir = JR_en | J_en | pc_branch.
- redir_target priority: JR_addr > J_addr > B_addr. Simultaneous requests are legal and resolved by this priority.
- Delay slot: decode resolves a branch while IF already fetches the slot at branch_PC+4. The redirect replaces the next sequential step, so the slot always executes and no flush is generated.
- State RUN:
  - advance & redir: PC <= redir_target, stay RUN.
  - advance & !redir: PC <= PC+4.
  - !advance & redir: PC holds, pending_target <= redir_target, go HOLD.
  - !advance & !redir: PC holds.
- State HOLD (redirect_pending=1):
  - redir asserted: pending_target <= redir_target. The latest request wins, because a stalled decode re-presents the same request.
  - advance: PC <= pending_target, go RUN.
  - If redir and advance coincide, PC <= redir_target (the fresh value) and go RUN.
- Exactly one redirect is applied per HOLD episode.
- PC4 = PC+4, combinational. Wraps modulo 2^32: PC=FFFF_FFFC gives PC4=0000_0000.
- Flags are combinational from PC:
  - pc_misalign is set but PC is still loaded unaltered; the exception unit owns recovery.
  - pc_out_of_range uses unsigned compare.
- fetch_valid=1 except the first cycle after reset and any cycle where PC held due to imem_ready=0. stall alone keeps fetch_valid=1.
- No combinational path from imem_ready to PC (registered only). Flags and PC4 depend on the PC register only.

Decomposition:
- Shared macro header (existing `Word`/`Half` widths): add RESET_PC default, the PC_INC=4 constant, and RUN/HOLD state encodings.
- One natural sub-module: pc_redirect_buf. It is the one-entry pending slot plus HOLD state, with inputs redir/redir_target/advance and outputs pending/pending_target.
- The top level holds the PC register, +4 adder, priority mux and range checks.

Test Plan:
- Reset release, advance=1 for 3 cycles -> PC sequence 3000, 3004, 3008, 300C; fetch_valid 0 then 1; PC4 tracks PC+4.
- At PC=3010, pc_branch=1, B_addr=3040, advance=1 -> next PC=3040, redirect_pending never set.
- At PC=3020, J_en=1, J_addr=3100 with stall=1 for 3 cycles -> PC holds 3020, redirect_pending=1. On the first advance cycle PC=3100 and redirect_pending=0.
- JR_en=1, JR_addr=3200, J_en=1, J_addr=3300, pc_branch=1 together, advance=1 -> PC=3200 (priority).
- HOLD with pending 3100, then a new redir B_addr=3180 while imem_ready=0, then advance -> PC=3180. Assert reset mid-HOLD -> PC=3000, redirect_pending=0 immediately.
- JR_addr=3002 -> pc_misalign=1; JR_addr=7000 -> pc_out_of_range=1. PC forced FFFF_FFFC -> PC4=0000_0000, pc_out_of_range=1.
